key_search_scheduler: RTL and testbench
=======================================

Name: key_search_scheduler

Overview:
Splits a runtime key range across NUM_CORES parallel RC4 cracking cores, launches them, and monitors their succeeded/failed flags. On the first success it latches the winning key and core index and aborts every core. It reports exhaustion when all enabled cores fail. It sits above the per-core arcfour instances and replaces fixed per-core key bounds with runtime bounds.

Parameters:
NUM_CORES, 4, number of cracking cores; must be a power of two, at least 2.
KEY_BITS, 24, width of the searchable key space.
RAM_WIDTH, 8, bits per key byte.
KEY_LENGTH, 3, bytes per key; KEY_LENGTH*RAM_WIDTH >= KEY_BITS.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request pulse; sampled only in IDLE
search_lower  in  KEY_BITS  inclusive lower bound; sampled on accepted start
search_upper  in  KEY_BITS  inclusive upper bound; must be >= search_lower
core_start  out  NUM_CORES  per-core start pulse
core_reset  out  NUM_CORES  per-core abort/reset
core_lower  out  NUM_CORES*KEY_BITS  per-core inclusive lower bound, registered
core_upper  out  NUM_CORES*KEY_BITS  per-core inclusive upper bound, registered
core_succeeded  in  NUM_CORES  per-core success, level
core_failed  in  NUM_CORES  per-core range-exhausted, level
core_key  in  NUM_CORES*KEY_LENGTH*RAM_WIDTH  per-core current key
busy  out  1  search in progress
found  out  1  sticky success flag
exhausted  out  1  sticky failure flag
found_key  out  KEY_LENGTH*RAM_WIDTH  winning key
found_core  out  $clog2(NUM_CORES)  winning core index

Behaviour:
- Reset: state IDLE; busy, found, exhausted, found_key, found_core, core_start, core_lower, core_upper, enable mask and done mask all 0. core_reset is all-ones while reset is high.
- States: IDLE, PARTITION, LAUNCH, RUN, ABORT, DONE.
- IDLE: on start, latch the bounds, clear found/exhausted, set busy, move to PARTITION. start in any other state is ignored.
- Span = upper - lower + 1, computed in KEY_BITS+1 bits so the full range 0..2^KEY_BITS-1 does not overflow.
  - If span >= NUM_CORES: chunk = span >> log2(NUM_CORES). Core i gets lower = lower + i*chunk and upper = lower + (i+1)*chunk - 1. The last core's upper is forced to search_upper, so it absorbs the remainder.
  - If span < NUM_CORES: only core 0 is enabled, with the full range. All other cores are disabled and treated as done.
- PARTITION: writes one core's bounds per cycle (index 0..NUM_CORES-1) using a running adder, not a multiplier. Takes NUM_CORES cycles, then goes to LAUNCH.
- LAUNCH: one cycle. core_start = enable mask; all other cycles core_start = 0. Goes to RUN.
- Latency: start accepted at cycle 0, core_start high at cycle NUM_CORES+1.
- RUN:
  - Each cycle, OR core_failed & enable into the done mask.
  - If any core_succeeded & enable is seen at cycle t: the lowest asserting index wins. Latch found_core and that core's core_key. Go to ABORT.
  - Else, if the done mask equals all-ones, go to ABORT with the not-found outcome.
  - If success and the final failure arrive in the same cycle, success wins.
- ABORT: one cycle. core_reset = all-ones. Sets found (on success) or exhausted (otherwise) at t+1, then goes to DONE.
- DONE: one cycle. Clears busy, returns to IDLE.
- found, exhausted, found_key and found_core hold until the next accepted start.
- Mid-operation reset: immediate return to reset values; cores are reset through core_reset.
- core_succeeded or core_failed from disabled cores, or outside RUN, is ignored.

Decomposition:
- Package key_search_pkg holds:
  - the state enum (sched_state_t);
  - the localparam CORE_IDX_W = $clog2(NUM_CORES);
  - a function for lowest-set-bit priority encoding.
- Sub-module key_range_partitioner owns the span/chunk computation, the running-adder bound generation, and the core_lower/core_upper registers. It is driven by a load/step strobe from the FSM.

Test Plan:
- NUM_CORES=4, bounds 0x000000..0x3FFFFF:
  - core bounds are [0x000000..0x0FFFFF], [0x100000..0x1FFFFF], [0x200000..0x2FFFFF], [0x300000..0x3FFFFF];
  - core_start=4'b1111 for exactly one cycle, 5 cycles after start.
- In RUN, core 2 asserts succeeded with core_key=0x2A0513 -> core_reset=4'b1111 for one cycle, found=1, found_core=2, found_key=0x2A0513, busy drops one cycle later.
- Cores 1 and 3 succeed in the same cycle -> found_core=1.
- All four cores assert failed in different cycles -> exhausted=1 one cycle after the last failure; found stays 0.
- Bounds 0x000010..0x000012 (span 3) -> only core 0 enabled with [0x10..0x12]; core_start=4'b0001; core 0 failing alone gives exhausted=1.
- Full range 0..0xFFFFFF -> core 3 upper = 0xFFFFFF.
- start pulsed during RUN -> ignored.
- reset asserted mid-RUN -> the next cycle shows every output at its reset value, with core_reset all-ones while reset is high.

Source files
------------

// File: rtl/key_search_pkg.sv
// Shared types and helpers for the key search scheduler: FSM state encoding,
// index widths and a lowest-set-bit priority encoder.
package key_search_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PARTITION,
    LAUNCH,
    RUN,
    ABORT,
    DONE
  } sched_state_t;

  localparam int DEFAULT_NUM_CORES = 4;
  localparam int MAX_CORES         = 64;
  localparam int CORE_IDX_W        = $clog2(DEFAULT_NUM_CORES);

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic int unsigned lowest_set(input logic [MAX_CORES-1:0] vec);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_CORES - 1; i >= 0; i--) begin
      if (vec[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_range_partitioner.sv
// Splits [search_lower, search_upper] into NUM_CORES contiguous slices, writing
// one core's bounds per step with a running adder.
module key_range_partitioner
  import key_search_pkg::*;
#(
  parameter int NUM_CORES = DEFAULT_NUM_CORES,
  parameter int KEY_BITS  = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic                          step,
  input  logic [KEY_BITS-1:0]           search_lower,
  input  logic [KEY_BITS-1:0]           search_upper,
  output logic [NUM_CORES-1:0]          enable,
  output logic                          last,
  output logic [NUM_CORES*KEY_BITS-1:0] core_lower,
  output logic [NUM_CORES*KEY_BITS-1:0] core_upper
);

  localparam int IDX_W  = $clog2(NUM_CORES);
  localparam int SPAN_W = KEY_BITS + 1;

  logic [SPAN_W-1:0]             span;
  logic [KEY_BITS-1:0]           base_d, base_q, chunk_d, chunk_q, upper_d, upper_q;
  logic [KEY_BITS-1:0]           chunk_end;
  logic                          small_d, small_q;
  logic [IDX_W-1:0]              idx_d, idx_q;
  logic [NUM_CORES-1:0]          enable_d, enable_q;
  logic [NUM_CORES*KEY_BITS-1:0] lower_d, lower_q, upper_arr_d, upper_arr_q;

  assign last = (idx_q == IDX_W'(NUM_CORES - 1));

  // NOTE: every variable gets its hold value first so no path leaves a latch.
  always_comb begin
    base_d      = base_q;
    chunk_d     = chunk_q;
    upper_d     = upper_q;
    small_d     = small_q;
    idx_d       = idx_q;
    enable_d    = enable_q;
    lower_d     = lower_q;
    upper_arr_d = upper_arr_q;
    // The extra span bit keeps the full key space (2^KEY_BITS keys) exact.
    span        = {1'b0, search_upper} - {1'b0, search_lower} + SPAN_W'(1);
    chunk_end   = base_q + chunk_q - KEY_BITS'(1);

    if (load) begin
      base_d   = search_lower;
      upper_d  = search_upper;
      small_d  = (span < SPAN_W'(NUM_CORES));
      chunk_d  = KEY_BITS'(span >> IDX_W);
      idx_d    = '0;
      enable_d = small_d ? NUM_CORES'(1) : '1;
    end else if (step) begin
      if (small_q) begin
        lower_d[idx_q*KEY_BITS +: KEY_BITS]     = (idx_q == '0) ? base_q  : '0;
        upper_arr_d[idx_q*KEY_BITS +: KEY_BITS] = (idx_q == '0) ? upper_q : '0;
      end else begin
        lower_d[idx_q*KEY_BITS +: KEY_BITS]     = base_q;
        upper_arr_d[idx_q*KEY_BITS +: KEY_BITS] = last ? upper_q : chunk_end;
      end
      base_d = base_q + chunk_q;
      idx_d  = idx_q + IDX_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q      <= '0;
      chunk_q     <= '0;
      upper_q     <= '0;
      small_q     <= 1'b0;
      idx_q       <= '0;
      enable_q    <= '0;
      lower_q     <= '0;
      upper_arr_q <= '0;
    end else begin
      base_q      <= base_d;
      chunk_q     <= chunk_d;
      upper_q     <= upper_d;
      small_q     <= small_d;
      idx_q       <= idx_d;
      enable_q    <= enable_d;
      lower_q     <= lower_d;
      upper_arr_q <= upper_arr_d;
    end
  end

  assign enable     = enable_q;
  assign core_lower = lower_q;
  assign core_upper = upper_arr_q;

endmodule

// File: rtl/key_search_scheduler.sv
// Distributes a runtime key range over NUM_CORES RC4 cracking cores, launches
// them, and collects the first winning key or reports exhaustion.
module key_search_scheduler
  import key_search_pkg::*;
#(
  parameter int NUM_CORES  = DEFAULT_NUM_CORES,
  parameter int KEY_BITS   = 24,
  parameter int RAM_WIDTH  = 8,
  parameter int KEY_LENGTH = 3
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic [KEY_BITS-1:0]                      search_lower,
  input  logic [KEY_BITS-1:0]                      search_upper,
  output logic [NUM_CORES-1:0]                     core_start,
  output logic [NUM_CORES-1:0]                     core_reset,
  output logic [NUM_CORES*KEY_BITS-1:0]            core_lower,
  output logic [NUM_CORES*KEY_BITS-1:0]            core_upper,
  input  logic [NUM_CORES-1:0]                     core_succeeded,
  input  logic [NUM_CORES-1:0]                     core_failed,
  input  logic [NUM_CORES*KEY_LENGTH*RAM_WIDTH-1:0] core_key,
  output logic                                     busy,
  output logic                                     found,
  output logic                                     exhausted,
  output logic [KEY_LENGTH*RAM_WIDTH-1:0]          found_key,
  output logic [$clog2(NUM_CORES)-1:0]             found_core
);

  localparam int KW    = KEY_LENGTH * RAM_WIDTH;
  localparam int IDX_W = $clog2(NUM_CORES);

  sched_state_t         state_d, state_q;
  logic                 busy_d, busy_q, found_d, found_q, exhausted_d, exhausted_q;
  logic [KW-1:0]        found_key_d, found_key_q;
  logic [IDX_W-1:0]     found_core_d, found_core_q, win;
  logic [NUM_CORES-1:0] done_d, done_q, enable, hit;
  logic                 load, step, last;

  key_range_partitioner #(
    .NUM_CORES (NUM_CORES),
    .KEY_BITS  (KEY_BITS)
  ) u_partitioner (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .step         (step),
    .search_lower (search_lower),
    .search_upper (search_upper),
    .enable       (enable),
    .last         (last),
    .core_lower   (core_lower),
    .core_upper   (core_upper)
  );

  assign hit = core_succeeded & enable;
  assign win = IDX_W'(lowest_set(MAX_CORES'(hit)));

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    found_d      = found_q;
    exhausted_d  = exhausted_q;
    found_key_d  = found_key_q;
    found_core_d = found_core_q;
    done_d       = done_q;
    load         = 1'b0;
    step         = 1'b0;
    core_start   = '0;
    core_reset   = {NUM_CORES{reset}};

    case (state_q)
      IDLE: if (start) begin
        load         = 1'b1;
        busy_d       = 1'b1;
        found_d      = 1'b0;
        exhausted_d  = 1'b0;
        found_key_d  = '0;
        found_core_d = '0;
        done_d       = '0;
        state_d      = PARTITION;
      end
      PARTITION: begin
        step = 1'b1;
        if (last) state_d = LAUNCH;
      end
      LAUNCH: begin
        core_start = enable;
        done_d     = ~enable;   // disabled cores count as already finished
        state_d    = RUN;
      end
      RUN: begin
        done_d = done_q | (core_failed & enable);
        if (|hit) begin
          found_d      = 1'b1;
          found_core_d = win;
          found_key_d  = core_key[win*KW +: KW];
          state_d      = ABORT;
        end else if (&done_d) begin
          exhausted_d = 1'b1;
          state_d     = ABORT;
        end
      end
      ABORT: begin
        core_reset = '1;
        busy_d     = 1'b0;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
      found_key_q  <= '0;
      found_core_q <= '0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      found_q      <= found_d;
      exhausted_q  <= exhausted_d;
      found_key_q  <= found_key_d;
      found_core_q <= found_core_d;
      done_q       <= done_d;
    end
  end

  assign busy       = busy_q;
  assign found      = found_q;
  assign exhausted  = exhausted_q;
  assign found_key  = found_key_q;
  assign found_core = found_core_q;

endmodule

// File: tb/tb_key_search_scheduler.sv
// Directed bench for key_search_scheduler: partitioning, launch timing, success,
// tie-break, exhaustion, small spans, full range, ignored start and reset.
module tb_key_search_scheduler;

  localparam int NC = 4;
  localparam int KB = 24;
  localparam int KW = 24;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [KB-1:0]     search_lower, search_upper;
  logic [NC-1:0]     core_start, core_reset, core_succeeded, core_failed;
  logic [NC*KB-1:0]  core_lower, core_upper;
  logic [NC*KW-1:0]  core_key;
  logic              busy, found, exhausted;
  logic [KW-1:0]     found_key;
  logic [key_search_pkg::CORE_IDX_W-1:0] found_core;

  int n_checks = 0;
  int n_fail   = 0;

  key_search_scheduler #(
    .NUM_CORES (NC), .KEY_BITS (KB), .RAM_WIDTH (8), .KEY_LENGTH (3)
  ) dut (
    .clk (clk), .reset (reset), .start (start),
    .search_lower (search_lower), .search_upper (search_upper),
    .core_start (core_start), .core_reset (core_reset),
    .core_lower (core_lower), .core_upper (core_upper),
    .core_succeeded (core_succeeded), .core_failed (core_failed),
    .core_key (core_key), .busy (busy), .found (found),
    .exhausted (exhausted), .found_key (found_key), .found_core (found_core)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [KB-1:0] lo(input int i);
    return core_lower[i*KB +: KB];
  endfunction

  function automatic logic [KB-1:0] hi(input int i);
    return core_upper[i*KB +: KB];
  endfunction

  // Pulse start and walk to the LAUNCH cycle, checking launch latency on the way.
  task automatic launch(input logic [KB-1:0] l, input logic [KB-1:0] u,
                        input logic [NC-1:0] exp_start);
    search_lower = l;
    search_upper = u;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("found_cleared", found, 0);
    check("exhausted_cleared", exhausted, 0);
    tick(3);
    check("no_early_core_start", core_start, 0);
    tick();
    check("core_start_launch", core_start, exp_start);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    search_lower = '0;
    search_upper = '0;
    core_succeeded = '0;
    core_failed = '0;
    core_key = {24'h333333, 24'h2A0513, 24'h111111, 24'h000AAA};

    // Reset state
    tick(2);
    check("rst_core_reset", core_reset, 4'b1111);
    check("rst_busy", busy, 0);
    check("rst_found", found, 0);
    check("rst_exhausted", exhausted, 0);
    check("rst_found_key", found_key, 0);
    check("rst_found_core", found_core, 0);
    check("rst_core_start", core_start, 0);
    check("rst_core_lower", core_lower, 0);
    reset = 1'b0;
    #1;
    check("core_reset_released", core_reset, 0);

    // Even four-way split, core 2 wins
    launch(24'h000000, 24'h3FFFFF, 4'b1111);
    check("c0_lo", lo(0), 24'h000000);
    check("c0_hi", hi(0), 24'h0FFFFF);
    check("c1_lo", lo(1), 24'h100000);
    check("c1_hi", hi(1), 24'h1FFFFF);
    check("c2_lo", lo(2), 24'h200000);
    check("c2_hi", hi(2), 24'h2FFFFF);
    check("c3_lo", lo(3), 24'h300000);
    check("c3_hi", hi(3), 24'h3FFFFF);
    tick();
    check("core_start_one_cycle", core_start, 0);
    start = 1'b1;            // ignored outside IDLE
    search_lower = 24'h000050;
    search_upper = 24'h000051;
    tick();
    start = 1'b0;
    check("start_ignored_busy", busy, 1);
    check("start_ignored_bounds", lo(1), 24'h100000);
    check("start_ignored_no_abort", core_reset, 0);
    core_succeeded = 4'b0100;
    tick();
    core_succeeded = 4'b0000;
    check("abort_core_reset", core_reset, 4'b1111);
    check("found_set", found, 1);
    check("found_core_2", found_core, 2);
    check("found_key_2", found_key, 24'h2A0513);
    check("busy_during_abort", busy, 1);
    tick();
    check("busy_dropped", busy, 0);
    check("abort_one_cycle", core_reset, 0);
    tick();
    check("found_sticky", found, 1);
    check("found_key_sticky", found_key, 24'h2A0513);

    // Simultaneous success on cores 1 and 3: lowest index wins
    launch(24'h000000, 24'h3FFFFF, 4'b1111);
    tick();
    core_succeeded = 4'b1010;
    tick();
    core_succeeded = 4'b0000;
    check("tie_found", found, 1);
    check("tie_found_core", found_core, 1);
    check("tie_found_key", found_key, 24'h111111);
    tick(2);

    // All cores fail in different cycles
    launch(24'h000000, 24'h3FFFFF, 4'b1111);
    tick();
    core_failed = 4'b0001;
    tick();
    core_failed = 4'b0011;
    tick();
    core_failed = 4'b0111;
    tick();
    check("partial_fail_busy", busy, 1);
    check("partial_fail_not_exhausted", exhausted, 0);
    core_failed = 4'b1111;
    tick();
    core_failed = 4'b0000;
    check("exhausted_set", exhausted, 1);
    check("exhausted_found_zero", found, 0);
    check("exhausted_core_reset", core_reset, 4'b1111);
    tick(2);
    check("exhausted_sticky", exhausted, 1);

    // Span of 3 keys: only core 0 runs
    launch(24'h000010, 24'h000012, 4'b0001);
    check("small_c0_lo", lo(0), 24'h000010);
    check("small_c0_hi", hi(0), 24'h000012);
    tick();
    core_succeeded = 4'b1110;  // disabled cores are ignored
    core_failed = 4'b1110;
    tick();
    core_succeeded = 4'b0000;
    check("disabled_ignored_found", found, 0);
    check("disabled_ignored_busy", busy, 1);
    core_failed = 4'b0001;
    tick();
    core_failed = 4'b0000;
    check("small_exhausted", exhausted, 1);
    check("small_found_zero", found, 0);
    tick(2);

    // Full key space, then reset mid-RUN
    launch(24'h000000, 24'hFFFFFF, 4'b1111);
    check("full_c0_hi", hi(0), 24'h3FFFFF);
    check("full_c3_lo", lo(3), 24'hC00000);
    check("full_c3_hi", hi(3), 24'hFFFFFF);
    tick(2);
    reset = 1'b1;
    #1;
    check("midrun_core_reset", core_reset, 4'b1111);
    tick();
    check("midrun_busy", busy, 0);
    check("midrun_core_lower", core_lower, 0);
    check("midrun_core_upper", core_upper, 0);
    check("midrun_core_start", core_start, 0);
    check("midrun_exhausted", exhausted, 0);
    reset = 1'b0;
    tick();
    check("post_reset_idle_busy", busy, 0);
    check("post_reset_core_reset", core_reset, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
